// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchroniser plus per-channel debounce FSM
// producing a clean level and one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int unsigned N               = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [N-1:0] SW,
  output logic [N-1:0] sw_level,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         sw_any
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; one extra value keeps D=1 at width 1.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [N-1:0] sw_s1;
  logic [N-1:0] sw_s2;

  // Two-stage synchroniser for the asynchronous switch inputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          level_q;
    logic          level_nx;
    logic          rise_q;
    logic          rise_nx;
    logic          fall_q;
    logic          fall_nx;

    // Channel state, qualification counter and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        state   <= STABLE_LO;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        level_q <= level_nx;
        rise_q  <= rise_nx;
        fall_q  <= fall_nx;
      end
    end

    // Next state: any reversal during WAIT drops back to the stable state,
    // so qualification always restarts from zero.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level_q;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
        STABLE_LO: begin
          if (sw_s2[g]) begin
            state_nx = WAIT_HI;
            cnt_nx   = '0;
          end
        end
        WAIT_HI: begin
          if (!sw_s2[g]) begin
            state_nx = STABLE_LO;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = STABLE_HI;
            level_nx = 1'b1;
            rise_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!sw_s2[g]) begin
            state_nx = WAIT_LO;
            cnt_nx   = '0;
          end
        end
        WAIT_LO: begin
          if (sw_s2[g]) begin
            state_nx = STABLE_HI;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = STABLE_LO;
            level_nx = 1'b0;
            fall_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          level_nx = 1'b0;
        end
      endcase
    end

    assign sw_level[g] = level_q;
    assign sw_rise[g]  = rise_q;
    assign sw_fall[g]  = fall_q;
  end

  // Edge summary straight from the registered pulses.
  assign sw_any = |{sw_rise, sw_fall};

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two instances (D=4 and D=1) on a shared 2-bit switch
// bank, a run-length reference model, directed literal checks, random phase.
module tb_sw_debounce;

  localparam int unsigned NCH = 2;
  localparam int DA = 4;
  localparam int DB = 1;

  logic           CLOCK_50;
  logic           reset;
  logic [NCH-1:0] SW;

  logic [NCH-1:0] lvl_a, rise_a, fall_a;
  logic           any_a;
  logic [NCH-1:0] lvl_b, rise_b, fall_b;
  logic           any_b;

  int checks   = 0;
  int failures = 0;

  sw_debounce #(.N(NCH), .DEBOUNCE_CYCLES(DA)) u_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .SW(SW),
    .sw_level(lvl_a), .sw_rise(rise_a), .sw_fall(fall_a), .sw_any(any_a)
  );

  sw_debounce #(.N(NCH), .DEBOUNCE_CYCLES(DB)) u_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .SW(SW),
    .sw_level(lvl_b), .sw_rise(rise_b), .sw_fall(fall_b), .sw_any(any_b)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel flips its accepted level once the synchronised
  // input (raw SW two edges late) has disagreed with it on D+1 consecutive edges.
  int             ecnt;
  logic [NCH-1:0] d1, d2;
  int             runl [2][NCH];
  logic [NCH-1:0] mlvl [2];
  logic [NCH-1:0] mrise[2];
  logic [NCH-1:0] mfall[2];

  function automatic int dval(input int m);
    return (m == 0) ? DA : DB;
  endfunction

  initial begin
    ecnt = 0; d1 = '0; d2 = '0;
    for (int m = 0; m < 2; m++) begin
      mlvl[m] = '0; mrise[m] = '0; mfall[m] = '0;
      for (int i = 0; i < int'(NCH); i++) runl[m][i] = 0;
    end
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) begin
        ecnt = 0; d1 = '0; d2 = '0;
        for (int m = 0; m < 2; m++) begin
          mlvl[m] = '0; mrise[m] = '0; mfall[m] = '0;
          for (int i = 0; i < int'(NCH); i++) runl[m][i] = 0;
        end
      end else begin
        ecnt = ecnt + 1;
        for (int m = 0; m < 2; m++) begin
          mrise[m] = '0;
          mfall[m] = '0;
          for (int i = 0; i < int'(NCH); i++) begin
            if (d2[i] != mlvl[m][i]) begin
              runl[m][i] = runl[m][i] + 1;
              if (runl[m][i] == dval(m) + 1) begin
                mlvl[m][i] = d2[i];
                if (d2[i]) mrise[m][i] = 1'b1;
                else       mfall[m][i] = 1'b1;
                runl[m][i] = 0;
              end
            end else begin
              runl[m][i] = 0;
            end
          end
        end
        d2 = d1;
        d1 = SW;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge CLOCK_50) begin
    chk("a_level", 32'(lvl_a),  32'(mlvl[0]));
    chk("a_rise",  32'(rise_a), 32'(mrise[0]));
    chk("a_fall",  32'(fall_a), 32'(mfall[0]));
    chk("a_any",   32'(any_a),  32'(|{mrise[0], mfall[0]}));
    chk("b_level", 32'(lvl_b),  32'(mlvl[1]));
    chk("b_rise",  32'(rise_b), 32'(mrise[1]));
    chk("b_fall",  32'(fall_b), 32'(mfall[1]));
    chk("b_any",   32'(any_b),  32'(|{mrise[1], mfall[1]}));
  end

  // Return 1 time unit after edge n (edges counted from reset release).
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (ecnt < n) begin
      @(posedge CLOCK_50);
      #1;
      guard++;
      if (guard > 1000) begin
        chk("wait_edge_timeout", 32'(ecnt), 32'(n));
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    chk("in_reset_a", 32'({lvl_a, rise_a, fall_a, any_a}), 32'd0);
    chk("in_reset_b", 32'({lvl_b, rise_b, fall_b, any_b}), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold[NCH];
    SW = '0;
    reset = 1'b0;
    #1 reset = 1'b1;

    // Reset with quiet input: everything stays low.
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      wait_edge(e);
      chk("quiet_a", 32'({lvl_a, rise_a, fall_a, any_a}), 32'd0);
      chk("quiet_b", 32'({lvl_b, rise_b, fall_b, any_b}), 32'd0);
    end

    // Clean rise on channel 0 before edge 10.
    do_reset();
    wait_edge(9);
    SW = 2'b01;
    for (int e = 10; e <= 17; e++) begin
      wait_edge(e);
      chk("rise_a_level", 32'(lvl_a),  (e >= 16) ? 32'd1 : 32'd0);
      chk("rise_a_pulse", 32'(rise_a), (e == 16) ? 32'd1 : 32'd0);
      chk("rise_a_any",   32'(any_a),  (e == 16) ? 32'd1 : 32'd0);
      chk("rise_b_pulse", 32'(rise_b), (e == 13) ? 32'd1 : 32'd0);
    end

    // Bounce: 1,0,1,0 one cycle each, then hold 1.
    SW = 2'b00;
    do_reset();
    SW = 2'b01;
    wait_edge(1); chk("bounce_a1", 32'(rise_a), 32'd0); chk("bounce_b1", 32'(rise_b), 32'd0);
    SW = 2'b00;
    wait_edge(2); chk("bounce_a2", 32'(rise_a), 32'd0); chk("bounce_b2", 32'(rise_b), 32'd0);
    SW = 2'b01;
    wait_edge(3); chk("bounce_a3", 32'(rise_a), 32'd0); chk("bounce_b3", 32'(rise_b), 32'd0);
    SW = 2'b00;
    wait_edge(4); chk("bounce_a4", 32'(rise_a), 32'd0); chk("bounce_b4", 32'(rise_b), 32'd0);
    SW = 2'b01;
    for (int e = 5; e <= 13; e++) begin
      wait_edge(e);
      chk("bounce_a_rise", 32'(rise_a), (e == 11) ? 32'd1 : 32'd0);
      chk("bounce_b_rise", 32'(rise_b), (e == 8) ? 32'd1 : 32'd0);
    end

    // Clean fall: D=1 at k+3, D=4 at k+6.
    wait_edge(20);
    SW = 2'b00;
    for (int e = 21; e <= 28; e++) begin
      wait_edge(e);
      chk("fall_b_pulse", 32'(fall_b), (e == 24) ? 32'd1 : 32'd0);
      chk("fall_b_level", 32'(lvl_b),  (e < 24)  ? 32'd1 : 32'd0);
      chk("fall_a_pulse", 32'(fall_a), (e == 27) ? 32'd1 : 32'd0);
      chk("fall_a_level", 32'(lvl_a),  (e < 27)  ? 32'd1 : 32'd0);
    end

    // Reset mid-WAIT (D=4) and mid-pulse (D=1), then release with SW held high.
    do_reset();
    SW = 2'b01;
    wait_edge(4);
    chk("pre_rst_b_rise",  32'(rise_b), 32'd1);
    chk("pre_rst_b_level", 32'(lvl_b),  32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_a", 32'({lvl_a, rise_a, fall_a, any_a}), 32'd0);
    chk("async_rst_b", 32'({lvl_b, rise_b, fall_b, any_b}), 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      wait_edge(e);
      chk("rel_a_rise", 32'(rise_a), (e == 7) ? 32'd1 : 32'd0);
      chk("rel_b_rise", 32'(rise_b), (e == 4) ? 32'd1 : 32'd0);
    end

    // Both channels change together before edge 5.
    SW = 2'b00;
    do_reset();
    wait_edge(4);
    SW = 2'b11;
    for (int e = 5; e <= 13; e++) begin
      wait_edge(e);
      chk("dual_rise",  32'(rise_a), (e == 11) ? 32'd3 : 32'd0);
      chk("dual_any",   32'(any_a),  (e == 11) ? 32'd1 : 32'd0);
      chk("dual_level", 32'(lvl_a),  (e >= 11) ? 32'd3 : 32'd0);
    end

    // Random bouncing with occasional asynchronous reset pulses.
    SW = 2'b00;
    do_reset();
    for (int i = 0; i < int'(NCH); i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLOCK_50);
      #1;
      for (int i = 0; i < int'(NCH); i++) begin
        if (hold[i] == 0) begin
          SW[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 8));
        end else begin
          hold[i] = hold[i] - 1;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end

    repeat (3) @(posedge CLOCK_50);
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
